reduce_frame_acc: RTL and testbench
===================================

# reduce_frame_acc

Downstream consumer of the 4-input AND/OR/XOR reduction gate stage. It accepts one word's three gate results per handshake beat and accumulates them over a frame delimited by `in_last`. At frame close it presents a registered summary through a valid/ready output: frame-wide AND, OR and XOR parity, word count, and the count of words with a nonzero OR. Sits between the gate stage and the result logger/checker.

## Interface
- `MAX_WORDS`, default 16: maximum words per frame; the frame force-closes when reached.
- `CNT_W`, default 5: width of the count outputs; must satisfy 2^CNT_W > MAX_WORDS.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: gate results and `in_last` are valid.
- `in_ready` out 1: block can accept a beat.
- `in_and` in 1: AND gate output for the current word.
- `in_or` in 1: OR gate output for the current word.
- `in_xor` in 1: XOR gate output for the current word.
- `in_last` in 1: the current beat is the final word of the frame.
- `out_valid` out 1: frame summary is valid.
- `out_ready` in 1: consumer accepts the summary.
- `out_and_all` out 1: AND of all `in_and` values in the frame.
- `out_or_any` out 1: OR of all `in_or` values in the frame.
- `out_xor_par` out 1: XOR of all `in_xor` values in the frame.
- `out_count` out CNT_W: number of words in the frame (1..MAX_WORDS).
- `out_ones` out CNT_W: number of words with `in_or`=1.
- `out_trunc` out 1: frame was closed by reaching MAX_WORDS, not by `in_last`.
- `out_err` out 1: an inconsistent word was seen in the frame (see Configuration).

## Operation
- FSM states:
  - IDLE: no words accumulated.
  - ACC: at least one word accumulated, frame open.
  - HOLD: summary presented on the output.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and ACC, 0 in HOLD.
- Accumulator initial values, loaded on reset and on leaving HOLD: `and_acc`=1, `or_acc`=0, `xor_acc`=0, `cnt`=0, `ones`=0, `err`=0.
- On each accepted beat:
  - `and_acc &= in_and`; `or_acc |= in_or`; `xor_acc ^= in_xor`.
  - `cnt += 1`; `ones += in_or`.
- Frame close happens on an accepted beat with `in_last`=1, or when `cnt+1 == MAX_WORDS`. Whichever happens, the beat's own contribution is included.
  - Close with `in_last`=0 sets `out_trunc`=1.
  - If `in_last`=1 and the count reaches MAX_WORDS on the same beat, `out_trunc`=0.
- Transitions:
  - IDLE → ACC on a non-closing accept.
  - IDLE or ACC → HOLD on a closing accept. A single-word frame goes IDLE → HOLD directly.
  - HOLD → IDLE on `out_valid && out_ready`.
- Output fields are registered at close and held stable while `out_valid`=1, regardless of `out_ready`.
- Counters never wrap: the close rule bounds `cnt` at MAX_WORDS.

## Timing
- Reset values: `in_ready`=0 while `reset` is high, then 1 in IDLE; all other outputs 0; state IDLE.
- `out_valid` rises the cycle after the closing accept (latency 1).
- The summary is consumed in the cycle where `out_valid && out_ready`. `out_valid` falls and `in_ready` rises the following cycle. No new beat is accepted during the drain cycle.
- `out_ready` held high means back-to-back frames lose one cycle per frame (throughput 1 word/cycle within a frame).
- Reset asserted mid-frame or in HOLD discards the partial frame and pending summary immediately (asynchronously): outputs go to reset values and no summary is emitted.
- `in_valid` while `in_ready`=0 is ignored. The upstream stage must hold its data.

## Configuration
- `REDUCE_CONSISTENCY_CHECK_EN` defined:
  - Each accepted beat is checked for gate-consistency for 4-bit inputs. The beat is an error if `in_and`=1 with (`in_or`=0 or `in_xor`=1), or if `in_or`=0 with `in_xor`=1.
  - Any error sets the sticky `err` bit for the frame; it is presented on `out_err` with the summary.
- Not defined: the check logic is absent and `out_err` is tied to 0.

## Test plan
- Reset, then four beats (and,or,xor) = (0,1,1), (0,0,0), (1,1,0), (0,1,1), with `in_last` on the 4th and `out_ready`=1. Required one cycle later: `out_valid`=1, `out_and_all`=0, `out_or_any`=1, `out_xor_par`=0, `out_count`=4, `out_ones`=3, `out_trunc`=0, `out_err`=0.
- Single beat (1,1,0) with `in_last`=1 → IDLE → HOLD. Required: `out_and_all`=1, `out_or_any`=1, `out_count`=1, `out_ones`=1.
- 16 beats of (0,0,0) with `in_last`=0 → close after the 16th beat. Required: `out_count`=16, `out_ones`=0, `out_trunc`=1. A 17th beat offered starts a new frame only after the drain.
- Complete a frame with `out_ready`=0 for 5 cycles. Required: outputs stable, `in_ready`=0, extra `in_valid` ignored. Raise `out_ready` → `out_valid` drops and `in_ready` rises the next cycle.
- Assert `reset` after 2 beats of a frame. Required: all outputs reset immediately, no `out_valid`, and the next frame counts from 1.
- With `REDUCE_CONSISTENCY_CHECK_EN` defined, send beat (1,0,0) then (0,1,1) with `in_last`. Required: `out_err`=1. The next clean frame has `out_err`=0. Without the macro, `out_err`=0 for the same stimulus.

Source files
------------

// File: rtl/reduce_frame_acc.sv
// reduce_frame_acc: accumulates per-word AND/OR/XOR gate results over a frame
// delimited by in_last (or force-closed at MAX_WORDS) and presents a registered
// frame summary through a valid/ready output.
// Optional feature macro: REDUCE_CONSISTENCY_CHECK_EN enables the per-word
// gate-consistency check that drives out_err; without it out_err is tied to 0.
module reduce_frame_acc #(
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_and,
  input  logic             in_or,
  input  logic             in_xor,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and_all,
  output logic             out_or_any,
  output logic             out_xor_par,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_ones,
  output logic             out_trunc,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             and_acc;
  logic             or_acc;
  logic             xor_acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ones;

  logic             accept;
  logic             close;
  logic             and_new;
  logic             or_new;
  logic             xor_new;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] ones_inc;

  // in_ready is held low while reset is asserted, and in HOLD so the summary
  // cannot be overwritten; out_valid is simply the registered HOLD state.
  assign in_ready  = (state != HOLD) && !reset;
  assign out_valid = (state == HOLD);

  assign accept   = in_valid && in_ready;
  assign and_new  = and_acc & in_and;
  assign or_new   = or_acc | in_or;
  assign xor_new  = xor_acc ^ in_xor;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign ones_inc = ones + CNT_W'(in_or);

  // A frame closes on in_last or when this beat fills the frame; the closing
  // beat's own contribution is always part of the summary.
  assign close = accept && (in_last || (cnt_inc == MAX_CNT));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE/ACC collect words, HOLD waits for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = close ? HOLD : ACC;
        end
      end
      ACC: begin
        if (close) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulators and summary registers. At close the summary captures the
  // updated values and the accumulators return to their initial values, so
  // the next frame starts clean as soon as HOLD drains (no beat can arrive
  // while in HOLD). Summary fields stay put until the next close or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      and_acc     <= 1'b1;
      or_acc      <= 1'b0;
      xor_acc     <= 1'b0;
      cnt         <= '0;
      ones        <= '0;
      out_and_all <= 1'b0;
      out_or_any  <= 1'b0;
      out_xor_par <= 1'b0;
      out_count   <= '0;
      out_ones    <= '0;
      out_trunc   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        out_and_all <= and_new;
        out_or_any  <= or_new;
        out_xor_par <= xor_new;
        out_count   <= cnt_inc;
        out_ones    <= ones_inc;
        out_trunc   <= !in_last;
        and_acc     <= 1'b1;
        or_acc      <= 1'b0;
        xor_acc     <= 1'b0;
        cnt         <= '0;
        ones        <= '0;
      end else begin
        and_acc <= and_new;
        or_acc  <= or_new;
        xor_acc <= xor_new;
        cnt     <= cnt_inc;
        ones    <= ones_inc;
      end
    end
  end

`ifdef REDUCE_CONSISTENCY_CHECK_EN
  logic beat_err;
  logic err_acc;
  logic err_new;
  logic err_q;

  // A word from a 4-input gate stage can never have AND=1 without OR=1 and
  // even parity, nor odd parity without OR=1.
  assign beat_err = (in_and && (!in_or || in_xor)) || (!in_or && in_xor);
  assign err_new  = err_acc | beat_err;
  assign out_err  = err_q;

  // Sticky per-frame error flag, captured into the summary at close.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_acc <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        err_q   <= err_new;
        err_acc <= 1'b0;
      end else begin
        err_acc <= err_new;
      end
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_reduce_frame_acc.sv
// Self-checking bench for reduce_frame_acc: directed scenarios plus random
// frames, checked against a frame-level reference model built from queued beats.
module tb_reduce_frame_acc;

  localparam int MAX_WORDS = 16;
  localparam int CNT_W     = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_and;
  logic             in_or;
  logic             in_xor;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_and_all;
  logic             out_or_any;
  logic             out_xor_par;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_ones;
  logic             out_trunc;
  logic             out_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: beats of the open frame as {and,or,xor}.
  logic [2:0] frame_q[$];
  logic       pending;
  logic       exp_and;
  logic       exp_or;
  logic       exp_xor;
  logic       exp_trunc;
  logic       exp_err;
  int         exp_count;
  int         exp_ones;

  reduce_frame_acc #(
    .MAX_WORDS(MAX_WORDS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_and     (in_and),
    .in_or      (in_or),
    .in_xor     (in_xor),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_and_all(out_and_all),
    .out_or_any (out_or_any),
    .out_xor_par(out_xor_par),
    .out_count  (out_count),
    .out_ones   (out_ones),
    .out_trunc  (out_trunc),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Summary of a closed frame computed straight from the list of its words.
  task automatic closeFrame(input logic by_last);
    exp_and   = 1'b1;
    exp_or    = 1'b0;
    exp_xor   = 1'b0;
    exp_err   = 1'b0;
    exp_ones  = 0;
    exp_count = frame_q.size();
    foreach (frame_q[i]) begin
      exp_and  = exp_and & frame_q[i][2];
      exp_or   = exp_or | frame_q[i][1];
      exp_xor  = exp_xor ^ frame_q[i][0];
      exp_ones = exp_ones + int'(frame_q[i][1]);
`ifdef REDUCE_CONSISTENCY_CHECK_EN
      if ((frame_q[i][2] && (!frame_q[i][1] || frame_q[i][0])) ||
          (!frame_q[i][1] && frame_q[i][0])) begin
        exp_err = 1'b1;
      end
`endif
    end
    exp_trunc = !by_last;
    pending   = 1'b1;
    frame_q.delete();
  endtask

  function automatic logic [31:0] obsPack();
    return {17'd0, out_and_all, out_or_any, out_xor_par, out_trunc, out_err, out_count, out_ones};
  endfunction

  function automatic logic [31:0] expPack();
    return {17'd0, exp_and, exp_or, exp_xor, exp_trunc, exp_err, 5'(exp_count), 5'(exp_ones)};
  endfunction

  // Offer one beat at the falling edge; it is accepted at the next rising edge.
  task automatic applyStimulus(input logic [2:0] beat, input logic last);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      in_valid = 1'b1;
      in_and   = beat[2];
      in_or    = beat[1];
      in_xor   = beat[0];
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      frame_q.push_back(beat);
      if (last || frame_q.size() == MAX_WORDS) closeFrame(last);
    end
  endtask

  // Check a summary one cycle after its closing beat, hold it for a number of
  // cycles with out_ready low while junk beats are offered, then drain it.
  task automatic checkSummary(input string tag, input int hold);
    checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, ".and_all"}, {31'd0, out_and_all}, {31'd0, exp_and});
    checkOutput({tag, ".or_any"}, {31'd0, out_or_any}, {31'd0, exp_or});
    checkOutput({tag, ".xor_par"}, {31'd0, out_xor_par}, {31'd0, exp_xor});
    checkOutput({tag, ".count"}, {27'd0, out_count}, 32'(exp_count));
    checkOutput({tag, ".ones"}, {27'd0, out_ones}, 32'(exp_ones));
    checkOutput({tag, ".trunc"}, {31'd0, out_trunc}, {31'd0, exp_trunc});
    checkOutput({tag, ".err"}, {31'd0, out_err}, {31'd0, exp_err});
    checkOutput({tag, ".in_ready_hold"}, {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_and    = 1'($urandom);
      in_or     = 1'($urandom);
      in_xor    = 1'($urandom);
      in_last   = 1'($urandom);
      @(negedge clk);
      checkOutput({tag, ".stable"}, obsPack(), expPack());
      checkOutput({tag, ".valid_held"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, ".ready_low"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".drained_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, ".drained_ready"}, {31'd0, in_ready}, 32'd1);
    pending = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_and    = 1'b0;
    in_or     = 1'b0;
    in_xor    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    pending   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.fields", obsPack(), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Four-word frame with out_ready held high
    $display("[TB] four-word frame");
    out_ready = 1'b1;
    applyStimulus(3'b011, 1'b0);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b110, 1'b0);
    applyStimulus(3'b011, 1'b1);
    checkOutput("frame4.pending", {31'd0, pending}, 32'd1);
    checkSummary("frame4", 0);

    // Single-word frame goes straight to HOLD
    $display("[TB] single-word frame");
    applyStimulus(3'b110, 1'b1);
    checkSummary("single", 0);

    // Sixteen words without in_last force-close; a further beat waits for the drain
    $display("[TB] truncated frame");
    for (int i = 0; i < MAX_WORDS; i++) begin
      applyStimulus(3'b000, 1'b0);
    end
    checkSummary("trunc16", 2);
    applyStimulus(3'b111, 1'b1);
    checkSummary("after_trunc", 0);

    // Backpressure: summary stays stable for five cycles
    $display("[TB] backpressure hold");
    applyStimulus(3'b111, 1'b0);
    applyStimulus(3'b110, 1'b1);
    checkSummary("hold5", 5);

    // Reset mid-frame discards the partial frame immediately
    $display("[TB] reset mid-frame");
    applyStimulus(3'b011, 1'b0);
    applyStimulus(3'b110, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset.in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midreset.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset.fields", obsPack(), 32'd0);
    frame_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postreset.no_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(3'b011, 1'b0);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b011, 1'b1);
    checkSummary("postreset_frame", 0);

    // Inconsistent words followed by a clean frame
    $display("[TB] consistency frames");
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b011, 1'b1);
    checkSummary("err_frame", 0);
    applyStimulus(3'b110, 1'b0);
    applyStimulus(3'b011, 1'b1);
    checkSummary("clean_frame", 1);

    // Random frames, some longer than MAX_WORDS, with random gaps and backpressure
    $display("[TB] random frames");
    for (int f = 0; f < 16; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        applyStimulus(3'($urandom), (i == len - 1));
        if (pending) checkSummary("random", $urandom_range(0, 3));
      end
    end
    checkOutput("random.model_empty", 32'(frame_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
